ripple_carry_adder_4_bit: RTL and testbench

//   Registered N-bit (default 4) unsigned ripple-carry adder: sum/carry = a + b + c_in.

---
 rtl/ripple_carry_adder_4_bit_if.sv | 68 ++++++
 rtl/ripple_carry_adder_4_bit.sv | 86 ++++++++
 tb/tb_ripple_carry_adder_4_bit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ripple_carry_adder_4_bit_if.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_4_bit_if
//   Operand/result bundle for the registered ripple-carry adder.
//
//   Signals
//     a        WIDTH  operand A, unsigned           (master -> slave)
//     b        WIDTH  operand B, unsigned           (master -> slave)
//     c_in     1      carry-in to bit 0             (master -> slave)
//     sum      WIDTH  registered sum                (slave -> master)
//     carry    1      registered carry-out          (slave -> master)
//     overflow 1      registered signed overflow    (slave -> master)
//                     present only with RCA_OVERFLOW_EN defined
//
//   Modports
//     master : operand source / result consumer
//     slave  : the adder itself
//
//   Build option: RCA_OVERFLOW_EN adds the overflow signal.
// ---------------------------------------------------------------------------
interface ripple_carry_adder_4_bit_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             carry;

`ifdef RCA_OVERFLOW_EN
  logic             overflow;

  modport master (
    output a,
    output b,
    output c_in,
    input  sum,
    input  carry,
    input  overflow
  );

  modport slave (
    input  a,
    input  b,
    input  c_in,
    output sum,
    output carry,
    output overflow
  );
`else
  modport master (
    output a,
    output b,
    output c_in,
    input  sum,
    input  carry
  );

  modport slave (
    input  a,
    input  b,
    input  c_in,
    output sum,
    output carry
  );
`endif

endinterface

// File: rtl/ripple_carry_adder_4_bit.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_4_bit
//   Registered WIDTH-bit unsigned ripple-carry adder:
//     {carry, sum} <= a + b + c_in   (one cycle latency, one result per cycle)
//   The combinational path is a plain chain of 1-bit full-adder cells with no
//   lookahead; the result is captured in an output register.
//
//   Ports
//     clk_i  in   1      clock, all state updates on the rising edge
//     rst_i  in   1      synchronous active-high reset; clears the outputs
//                        and overrides any add on the same edge
//     bus    slave       operands a/b/c_in in, registered sum/carry
//                        (and overflow) out, see ripple_carry_adder_4_bit_if
//
//   Parameters
//     WIDTH  operand/sum width, >= 1; must match the interface WIDTH
//
//   Build option
//     RCA_OVERFLOW_EN  adds a registered two's-complement overflow flag
//                      (carry into MSB xor carry out of MSB). sum/carry are
//                      identical with or without it.
// ---------------------------------------------------------------------------
module ripple_carry_adder_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ripple_carry_adder_4_bit_if.slave   bus
);

  // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB cell.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;

  assign c[0] = bus.c_in;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;  // propagate
    logic g;  // generate
    assign p        = bus.a[i] ^ bus.b[i];
    assign g        = bus.a[i] & bus.b[i];
    assign s[i]     = p ^ c[i];
    assign c[i+1]   = g | (c[i] & p);
  end

  assign sum_d   = s;
  assign carry_d = c[WIDTH];

`ifdef RCA_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];
`endif

  // ---- output register stage ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef RCA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
`ifdef RCA_OVERFLOW_EN
  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_4_bit.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_adder_4_bit
//   Directed vectors for the registered ripple-carry adder (WIDTH=4).
//   Inputs change on the falling edge, results are read 1 time unit after
//   the rising edge that captures them.
//   Build with +define+RCA_OVERFLOW_EN to cover the overflow flag.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ripple_carry_adder_4_bit;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  int n_vec;
  int n_bad;

  ripple_carry_adder_4_bit_if #(.WIDTH(WIDTH)) bus ();

  ripple_carry_adder_4_bit #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one set of inputs for exactly one rising edge, then settle.
  task automatic apply(input logic r, input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    rst      = r;
    bus.a    = a;
    bus.b    = b;
    bus.c_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci,
                     input logic [3:0] exp_sum, input logic exp_carry);
    apply(1'b0, a, b, ci);
    chk({tag, ".sum"},   32'(bus.sum),   32'(exp_sum));
    chk({tag, ".carry"}, 32'(bus.carry), 32'(exp_carry));
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    bus.a    = '0;
    bus.b    = '0;
    bus.c_in = 1'b0;

    // Reset held for two edges with nonzero operands: outputs stay zero.
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 4'd9, 4'd9, 1'b1);
      chk("rst.sum",   32'(bus.sum),   32'd0);
      chk("rst.carry", 32'(bus.carry), 32'd0);
`ifdef RCA_OVERFLOW_EN
      chk("rst.ovf",   32'(bus.overflow), 32'd0);
`endif
    end

    // Basic sums, back-to-back, one new operand set per cycle.
    vec("z",    4'd0,  4'd0,  1'b0, 4'd0,  1'b0);
    vec("1+1",  4'd1,  4'd1,  1'b0, 4'd2,  1'b0);
    vec("2+2c", 4'd2,  4'd2,  1'b1, 4'd5,  1'b0);
    vec("6+3c", 4'd6,  4'd3,  1'b1, 4'd10, 1'b0);
    vec("5+5c", 4'd5,  4'd5,  1'b1, 4'd11, 1'b0);
    vec("3+4c", 4'd3,  4'd4,  1'b1, 4'd8,  1'b0);

    // Carry out of the MSB.
    vec("a+7c", 4'd10, 4'd7,  1'b1, 4'd2,  1'b1);
    vec("e+7c", 4'd14, 4'd7,  1'b1, 4'd6,  1'b1);
    vec("7+fc", 4'd7,  4'd15, 1'b1, 4'd7,  1'b1);

    // Full wrap-around: 15+15+1 = 31.
    vec("wrap", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);

    // Reset between two operand sets: zero on the reset edge, then resume.
    vec("pre",  4'd3,  4'd4,  1'b1, 4'd8,  1'b0);
    apply(1'b1, 4'd10, 4'd7, 1'b1);
    chk("mid.rst.sum",   32'(bus.sum),   32'd0);
    chk("mid.rst.carry", 32'(bus.carry), 32'd0);
    vec("post", 4'd10, 4'd7,  1'b1, 4'd2,  1'b1);

`ifdef RCA_OVERFLOW_EN
    apply(1'b0, 4'd7, 4'd1, 1'b0);
    chk("ovf1.sum",   32'(bus.sum),      32'd8);
    chk("ovf1.carry", 32'(bus.carry),    32'd0);
    chk("ovf1.ovf",   32'(bus.overflow), 32'd1);
    apply(1'b0, 4'd8, 4'd8, 1'b0);
    chk("ovf2.sum",   32'(bus.sum),      32'd0);
    chk("ovf2.carry", 32'(bus.carry),    32'd1);
    chk("ovf2.ovf",   32'(bus.overflow), 32'd1);
    apply(1'b0, 4'd14, 4'd7, 1'b1);
    chk("ovf3.ovf",   32'(bus.overflow), 32'd0);
`endif

    // Exhaustive sweep against integer a+b+c_in.
    for (int x = 0; x < 512; x++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      int         tot;
      ea  = 4'(x);
      eb  = 4'(x >> 4);
      ec  = 1'(x >> 8);
      tot = int'(ea) + int'(eb) + int'(ec);
      apply(1'b0, ea, eb, ec);
      chk("sweep.sum",   32'(bus.sum),   32'(tot % 16));
      chk("sweep.carry", 32'(bus.carry), 32'(tot / 16));
`ifdef RCA_OVERFLOW_EN
      begin
        int sa;
        int sb;
        int st;
        sa = (ea >= 4'd8) ? int'(ea) - 16 : int'(ea);
        sb = (eb >= 4'd8) ? int'(eb) - 16 : int'(eb);
        st = sa + sb + int'(ec);
        chk("sweep.ovf", 32'(bus.overflow), ((st > 7) || (st < -8)) ? 32'd1 : 32'd0);
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
